// File: rtl/pl_rv32_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pl_rv32_fetch_unit
// Purpose  : RV32 fetch stage - owns the PC, issues imem req/gnt/rvalid
//            fetches and feeds decode from a small in-order FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module pl_rv32_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_fault
);
  localparam int unsigned c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_cw = c_aw + 1;
  localparam int unsigned c_sw = c_cw + 1;
  localparam logic [c_sw-1:0] c_depth_s = c_sw'(DEPTH);
  localparam logic [c_cw-1:0] c_depth_c = c_cw'(DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          r_state, w_state_next;
  logic [31:0]     r_pc;
  logic            r_req_held;
  logic [31:0]     r_held_addr;
  logic            r_held_stale;
  logic [c_cw-1:0] r_outstanding, r_discard, r_occ;
  logic [c_aw-1:0] r_tq_wr, r_tq_rd, r_f_wr, r_f_rd;
  logic [31:0]     r_tq_mem  [DEPTH];
  logic [31:0]     r_f_instr [DEPTH];
  logic [31:0]     r_f_pc    [DEPTH];
  logic            r_f_fault [DEPTH];
  logic            r_fault_pending;
  logic [31:0]     r_fault_pc;

  logic            w_new_issue, w_accept, w_stale_accept, w_rv, w_drop;
  logic            w_data_push, w_fault_push, w_push, w_pop, w_misaligned;
  logic [c_sw-1:0] w_credit, w_out_sum, w_disc_sum;
  logic [c_cw-1:0] w_out_next, w_disc_next;

  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign w_credit     = c_sw'(r_outstanding) + c_sw'(r_occ) - c_sw'(id_valid & id_ready);

  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = w_misaligned ? ST_HALT : ST_RUN;
    end else if (r_state == ST_BOOT) begin
      w_state_next = ST_RUN;
    end
    w_new_issue = (r_state == ST_RUN) && !r_req_held && (w_credit < c_depth_s);
  end

  // A request that saw no grant is replayed unchanged, even after a redirect.
  assign imem_req       = r_req_held | w_new_issue;
  assign imem_addr      = r_req_held ? r_held_addr : r_pc;
  assign w_accept       = imem_req & imem_gnt;
  assign w_stale_accept = w_accept & r_req_held & r_held_stale;

  // Responses with nothing outstanding (e.g. straddling a reset) are ignored.
  assign w_rv         = imem_rvalid & (r_outstanding != '0);
  assign w_drop       = w_rv & (r_discard != '0);
  assign w_data_push  = w_rv & (r_discard == '0) & ~redirect_valid;
  assign w_fault_push = r_fault_pending & (r_discard == '0) & ~redirect_valid & ~w_data_push;
  assign w_push       = w_data_push | w_fault_push;
  assign w_pop        = id_valid & id_ready & ~redirect_valid;

  assign w_out_sum  = c_sw'(r_outstanding) + c_sw'(w_accept) - c_sw'(w_rv);
  assign w_out_next = (w_out_sum > c_depth_s) ? c_depth_c : w_out_sum[c_cw-1:0];
  // On a redirect every response still owed to us is stale.
  assign w_disc_sum  = redirect_valid ? w_out_sum
                     : c_sw'(r_discard) - c_sw'(w_drop) + c_sw'(w_stale_accept);
  assign w_disc_next = (w_disc_sum > c_depth_s) ? c_depth_c : w_disc_sum[c_cw-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_BOOT;
      r_pc            <= RESET_PC;
      r_req_held      <= 1'b0;
      r_held_addr     <= RESET_PC;
      r_held_stale    <= 1'b0;
      r_outstanding   <= '0;
      r_discard       <= '0;
      r_occ           <= '0;
      r_tq_wr         <= '0;
      r_tq_rd         <= '0;
      r_f_wr          <= '0;
      r_f_rd          <= '0;
      r_fault_pending <= 1'b0;
      r_fault_pc      <= 32'h0;
    end else begin
      r_state       <= w_state_next;
      r_req_held    <= imem_req & ~imem_gnt;
      r_held_addr   <= imem_addr;
      r_held_stale  <= imem_req & ~imem_gnt & (r_held_stale | redirect_valid);
      r_outstanding <= w_out_next;
      r_discard     <= w_disc_next;
      if (redirect_valid) begin
        r_pc <= redirect_pc;
      end else if (w_accept && !w_stale_accept) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_accept) r_tq_wr <= r_tq_wr + c_aw'(1);
      if (w_rv)     r_tq_rd <= r_tq_rd + c_aw'(1);
      if (redirect_valid) begin
        r_occ  <= '0;
        r_f_wr <= '0;
        r_f_rd <= '0;
      end else begin
        if (w_push) r_f_wr <= r_f_wr + c_aw'(1);
        if (w_pop)  r_f_rd <= r_f_rd + c_aw'(1);
        r_occ <= r_occ + c_cw'(w_push) - c_cw'(w_pop);
      end
      if (redirect_valid) begin
        r_fault_pending <= w_misaligned;
        r_fault_pc      <= redirect_pc;
      end else if (w_fault_push) begin
        r_fault_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_tq_mem[r_tq_wr] <= imem_addr;
    if (w_push) begin
      r_f_instr[r_f_wr] <= w_fault_push ? NOP_INSTR : imem_rdata;
      r_f_pc[r_f_wr]    <= w_fault_push ? r_fault_pc : r_tq_mem[r_tq_rd];
      r_f_fault[r_f_wr] <= w_fault_push;
    end
  end

  assign id_valid = (r_occ != '0);
  assign id_instr = id_valid ? r_f_instr[r_f_rd] : NOP_INSTR;
  assign id_pc    = id_valid ? r_f_pc[r_f_rd] : 32'h0;
  assign id_fault = id_valid & r_f_fault[r_f_rd];

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (w_out_sum <= c_depth_s);
      assert (w_disc_sum <= c_depth_s);
      assert (!(imem_rvalid && (r_outstanding == '0)));
    end
  end
`endif

endmodule
`default_nettype wire
